// File: rtl/btn_input_ctrl.sv
`timescale 1ns/1ps
// Push-button conditioner: 2-flop sync, per-button debounce FSM,
// registered level plus press/release/long one-cycle pulses.
module btn_input_ctrl #(
  parameter int N_BTN       = 4,
  parameter int DB_CYCLES   = 1_000_000,
  parameter int LONG_CYCLES = 50_000_000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] long_o
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int HW  = $clog2(LONG_CYCLES + 1);

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [DBW-1:0] DB_ONE   = DBW'(1);
  localparam logic [HW-1:0]  HOLD_MAX = HW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    REL_WAIT
  } state_e;

  state_e           st_q   [N_BTN];
  state_e           st_d   [N_BTN];
  logic [DBW-1:0]   db_q   [N_BTN];
  logic [DBW-1:0]   db_d   [N_BTN];
  logic [HW-1:0]    hold_q [N_BTN];
  logic [HW-1:0]    hold_d [N_BTN];

  logic [N_BTN-1:0] s1_q, s2_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] rel_q, rel_d;
  logic [N_BTN-1:0] long_q, long_d;

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      st_d[i]    = st_q[i];
      db_d[i]    = db_q[i];
      hold_d[i]  = hold_q[i];
      level_d[i] = level_q[i];
      press_d[i] = 1'b0;
      rel_d[i]   = 1'b0;
      long_d[i]  = 1'b0;

      // hold time keeps running through a release bounce
      if (st_q[i] == PRESSED || st_q[i] == REL_WAIT) begin
        if (hold_q[i] != HOLD_MAX) begin
          hold_d[i] = hold_q[i] + 1'b1;
          long_d[i] = (hold_d[i] == HOLD_MAX);
        end
      end

      unique case (st_q[i])
        IDLE: begin
          if (s2_q[i]) begin
            st_d[i] = PRESS_WAIT;
            db_d[i] = DB_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!s2_q[i]) begin
            st_d[i] = IDLE;
            db_d[i] = '0;
          end else if (db_q[i] == DB_LAST) begin
            st_d[i]    = PRESSED;
            db_d[i]    = '0;
            press_d[i] = 1'b1;
            level_d[i] = 1'b1;
            hold_d[i]  = '0;
          end else begin
            db_d[i] = db_q[i] + 1'b1;
          end
        end
        PRESSED: begin
          if (!s2_q[i]) begin
            st_d[i] = REL_WAIT;
            db_d[i] = DB_ONE;
          end
        end
        REL_WAIT: begin
          if (s2_q[i]) begin
            st_d[i] = PRESSED;
            db_d[i] = '0;
          end else if (db_q[i] == DB_LAST) begin
            st_d[i]    = IDLE;
            db_d[i]    = '0;
            rel_d[i]   = 1'b1;
            level_d[i] = 1'b0;
          end else begin
            db_d[i] = db_q[i] + 1'b1;
          end
        end
        default: begin
          st_d[i]    = IDLE;
          db_d[i]    = '0;
          hold_d[i]  = '0;
          level_d[i] = 1'b0;
          long_d[i]  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        st_q[i]   <= IDLE;
        db_q[i]   <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      for (int i = 0; i < N_BTN; i++) begin
        st_q[i]   <= st_d[i];
        db_q[i]   <= db_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign long_o    = long_q;

endmodule

// File: tb/tb_btn_input_ctrl.sv
`timescale 1ns/1ps
// Directed bench for btn_input_ctrl with DB_CYCLES=4, LONG_CYCLES=16.
module tb_btn_input_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [3:0] btn;
  logic [3:0] level, press, rel, lng;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  int np [4], nr [4], nl [4];
  int pe [4], re [4], le [4];

  btn_input_ctrl #(
    .N_BTN(4),
    .DB_CYCLES(4),
    .LONG_CYCLES(16)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .btn_i(btn),
    .level_o(level),
    .press_o(press),
    .release_o(rel),
    .long_o(lng)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) begin
      np[i] = 0; nr[i] = 0; nl[i] = 0;
      pe[i] = -1; re[i] = -1; le[i] = -1;
    end
  endtask

  // advance to just after edge e, tallying pulses per button
  task automatic watch(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (press[i]) begin np[i]++; if (pe[i] < 0) pe[i] = cyc; end
        if (rel[i])   begin nr[i]++; if (re[i] < 0) re[i] = cyc; end
        if (lng[i])   begin nl[i]++; if (le[i] < 0) le[i] = cyc; end
      end
    end
  endtask

  int b, c, d, e, drops;

  initial begin
    rst_ni = 1'b0;
    btn    = 4'b0000;
    clr();
    #1;
    chk("rst_level", level, 4'b0000);
    chk("rst_press", press, 4'b0000);
    chk("rst_rel",   rel,   4'b0000);
    chk("rst_long",  lng,   4'b0000);
    #1 rst_ni = 1'b1;

    // clean press on button 0
    watch(9);
    btn = 4'b0001;
    watch(14);
    chk("s1_level_pre", level, 4'b0000);
    watch(15);
    chk("s1_press15", press, 4'b0001);
    chk("s1_level15", level, 4'b0001);
    watch(39);
    btn = 4'b0000;
    watch(50);
    chk("s1_np",  np[0], 1);
    chk("s1_nl",  nl[0], 1);
    chk("s1_le",  le[0], 31);
    chk("s1_nr",  nr[0], 1);
    chk("s1_re",  re[0], 45);
    chk("s1_lvl", level, 4'b0000);

    // bounce rejection on button 1
    clr();
    b = 60;
    watch(b + 15); btn[1] = 1'b1;
    watch(b + 16); btn[1] = 1'b0;
    watch(b + 17); btn[1] = 1'b1;
    watch(b + 18); btn[1] = 1'b0;
    watch(b + 19); btn[1] = 1'b1;
    watch(b + 24);
    chk("s2_nopulse", np[1] + nr[1] + nl[1], 0);
    watch(b + 30);
    chk("s2_np", np[1], 1);
    chk("s2_pe", pe[1], b + 25);
    btn[1] = 1'b0;
    watch(b + 45);
    chk("s2_re", re[1], b + 36);
    chk("s2_nl", nl[1], 0);

    // release glitch on button 2
    clr();
    c = 120;
    watch(c); btn[2] = 1'b1;
    watch(c + 10); btn[2] = 1'b0;
    watch(c + 12); btn[2] = 1'b1;
    drops = 0;
    while (cyc < c + 30) begin
      watch(cyc + 1);
      if (!level[2]) drops++;
    end
    chk("s3_pe",    pe[2], c + 6);
    chk("s3_drops", drops, 0);
    chk("s3_nr",    nr[2], 0);
    chk("s3_nl",    nl[2], 1);
    chk("s3_le",    le[2], c + 22);
    btn[2] = 1'b0;
    watch(c + 40);
    chk("s3_re", re[2], c + 36);

    // short press on button 3
    clr();
    d = 170;
    watch(d); btn[3] = 1'b1;
    watch(d + 10); btn[3] = 1'b0;
    watch(d + 40);
    chk("s4_np", np[3], 1);
    chk("s4_pe", pe[3], d + 6);
    chk("s4_nr", nr[3], 1);
    chk("s4_re", re[3], d + 16);
    chk("s4_nl", nl[3], 0);

    // simultaneous press on all buttons
    clr();
    e = 220;
    watch(e); btn = 4'b1111;
    watch(e + 5);
    chk("s5_press_pre", press, 4'b0000);
    watch(e + 6);
    chk("s5_press", press, 4'b1111);
    chk("s5_level", level, 4'b1111);
    watch(e + 7);
    chk("s5_press_1cyc", press, 4'b0000);
    btn = 4'b0101;
    watch(e + 13);
    chk("s5_rel", rel, 4'b1010);
    watch(e + 16);
    chk("s5_lvl0101", level, 4'b0101);

    // reset mid-operation with buttons still held
    rst_ni = 1'b0;
    #1;
    chk("s6_level", level, 4'b0000);
    chk("s6_press", press, 4'b0000);
    chk("s6_rel",   rel,   4'b0000);
    chk("s6_long",  lng,   4'b0000);
    watch(e + 18);
    rst_ni = 1'b1;
    clr();
    watch(e + 23);
    chk("s6_press_pre", press, 4'b0000);
    watch(e + 24);
    chk("s6_press", press, 4'b0101);
    chk("s6_lvl",   level, 4'b0101);
    watch(e + 26);
    chk("s6_np0", np[0], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
